// File: rtl/audio_regs_pkg.sv
// Shared constants for the codec register bank: addresses, ROUTE source codes and FIFO_CTRL bits.
package audio_regs_pkg;

  localparam logic [6:0] ADDR_ID         = 7'h00;
  localparam logic [6:0] ADDR_PINC_BASE  = 7'h01;
  localparam logic [6:0] ADDR_ROUTE      = 7'h08;
  localparam logic [6:0] ADDR_SCRATCH    = 7'h0A;
  localparam logic [6:0] ADDR_FIFO_CTRL  = 7'h10;
  localparam logic [6:0] ADDR_FIFO_DATA  = 7'h11;
  localparam logic [6:0] ADDR_SAMPLE_CNT = 7'h12;
  localparam logic [6:0] ADDR_SNAP_R     = 7'h13;
  localparam logic [6:0] ADDR_SNAP_L     = 7'h14;

  localparam logic [31:0] ID_VALUE     = 32'hA0D1_0002;
  localparam logic [31:0] READ_DEFAULT = 32'hDEADC0DE;
  localparam logic [31:0] ROUTE_RST    = 32'h0000_00E0;

  localparam logic [3:0] SRC_ADC_R = 4'hD;
  localparam logic [3:0] SRC_ADC_L = 4'hE;
  localparam logic [3:0] SRC_MUTE  = 4'hF;

  localparam int CTRL_EMPTY_BIT = 16;
  localparam int CTRL_FULL_BIT  = 17;
  localparam int CTRL_OVF_BIT   = 18;
  localparam int CTRL_CAP_BIT   = 19;
  localparam int CTRL_CH_BIT    = 20;
  localparam int CTRL_FLUSH_BIT = 31;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO for ADC capture; pointers carry one extra bit to tell full from empty.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/audio_regfile.sv
// Codec register bank on the UART cmd bus: DDS phase increments, DAC routing, ADC snapshot and counter.
// Capture FIFO (regs 0x10/0x11) present only when AUDIO_REGFILE_FIFO_EN is defined.
module audio_regfile
  import audio_regs_pkg::*;
#(
  parameter int          NUM_DDS    = 2,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] PINC_RST   = 32'd500000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    re,
  input  logic [6:0]              addr,
  input  logic [31:0]             wdat,
  output logic [31:0]             rdat,
  input  logic [16*NUM_DDS-1:0]   dds_sin,
  output logic [32*NUM_DDS-1:0]   phase_inc,
  input  logic [23:0]             adc_l,
  input  logic [23:0]             adc_r,
  input  logic                    adc_update,
  output logic [23:0]             dac_l,
  output logic [23:0]             dac_r
);

  logic [31:0] pinc [NUM_DDS];
  logic [31:0] route;
  logic [31:0] scratch;
  logic [31:0] sample_cnt;
  logic [23:0] snap_l;
  logic [23:0] snap_r;

  for (genvar k = 0; k < NUM_DDS; k++) begin : g_pinc
    assign phase_inc[32*k +: 32] = pinc[k];
  end

  function automatic logic [23:0] route_word(input logic [3:0] code);
    route_word = 24'h0;
    if (code == SRC_ADC_R) route_word = adc_r;
    else if (code == SRC_ADC_L) route_word = adc_l;
    else if (code != SRC_MUTE) begin
      for (int k = 0; k < NUM_DDS; k++)
        if (code == 4'(k)) route_word = {dds_sin[16*k +: 16], 8'h00};
    end
  endfunction

  // ROUTE owns 0x08 should NUM_DDS reach 8 and its phase window overlap it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DDS; k++) pinc[k] <= PINC_RST;
      route   <= ROUTE_RST;
      scratch <= '0;
    end else if (we) begin
      for (int k = 0; k < NUM_DDS; k++)
        if (addr == 7'(ADDR_PINC_BASE + k) && addr != ADDR_ROUTE) pinc[k] <= wdat;
      if (addr == ADDR_ROUTE)   route   <= wdat;
      if (addr == ADDR_SCRATCH) scratch <= wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      snap_l     <= '0;
      snap_r     <= '0;
      dac_l      <= '0;
      dac_r      <= '0;
    end else begin
      if (adc_update) begin
        sample_cnt <= sample_cnt + 32'd1;
        snap_l     <= adc_l;
        snap_r     <= adc_r;
      end
      dac_l <= route_word(route[3:0]);
      dac_r <= route_word(route[7:4]);
    end
  end

`ifdef AUDIO_REGFILE_FIFO_EN
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          cap;
  logic          ch;
  logic          ovf;
  logic          ctrl_wr;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_flush;
  logic [23:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  assign ctrl_wr    = we && (addr == ADDR_FIFO_CTRL);
  assign fifo_push  = adc_update && cap;
  assign fifo_pop   = re && (addr == ADDR_FIFO_DATA);
  assign fifo_flush = ctrl_wr && wdat[CTRL_FLUSH_BIT];

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(24)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (ch ? adc_r : adc_l),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A pop on a full FIFO makes room, so only an unmatched push into full overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap <= 1'b0;
      ch  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        cap <= wdat[CTRL_CAP_BIT];
        ch  <= wdat[CTRL_CH_BIT];
      end
      if (fifo_flush || (ctrl_wr && wdat[CTRL_OVF_BIT])) ovf <= 1'b0;
      else if (fifo_push && fifo_full && !fifo_pop)       ovf <= 1'b1;
    end
  end
`else
  logic unused_re;
  assign unused_re = re;
`endif

  always_comb begin
    rdat = READ_DEFAULT;
    for (int k = 0; k < NUM_DDS; k++)
      if (addr == 7'(ADDR_PINC_BASE + k)) rdat = pinc[k];
    case (addr)
      ADDR_ID:         rdat = ID_VALUE;
      ADDR_ROUTE:      rdat = route;
      ADDR_SCRATCH:    rdat = scratch;
      ADDR_SAMPLE_CNT: rdat = sample_cnt;
      ADDR_SNAP_R:     rdat = {snap_r, 8'h00};
      ADDR_SNAP_L:     rdat = {snap_l, 8'h00};
`ifdef AUDIO_REGFILE_FIFO_EN
      ADDR_FIFO_CTRL:  rdat = {11'h0, ch, cap, ovf, fifo_full, fifo_empty, 16'(fifo_count)};
      ADDR_FIFO_DATA:  rdat = fifo_empty ? 32'h0 : {fifo_head, 8'h00};
`endif
      default: ;
    endcase
  end

endmodule
